// File: rtl/ice40_ram_pkg.sv
// Shared helpers for the iCE40 block-RAM FIFO.
//   clog2          - ceiling log2 usable in constant expressions
//   fifo_params_ok - legality of the ice40_ram_fifo parameter set
package ice40_ram_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < value) r++;
      return r;
   endfunction

   function automatic bit fifo_params_ok(input int unsigned width,
                                         input int unsigned depth,
                                         input int unsigned afull_level);
      return (width >= 1) && (width <= 32) &&
             (depth >= 2) && (depth <= 4096) && ((depth & (depth - 1)) == 0) &&
             (afull_level >= 1) && (afull_level <= depth + 1);
   endfunction

endpackage

// File: rtl/ice40_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
// Written behaviourally so synthesis maps it onto cascaded SB_RAM40_4K blocks.
//   clk    - clock for both ports
//   rst_n  - async active-low reset, clears only the read register
//   we     - write enable; waddr / wdata - write address / data
//   re     - read enable; raddr - read address
//   rdata  - registered read data, holds while re is low
module ice40_ram_sdp import ice40_ram_pkg::*; #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Array contents are never reset, as in the block RAM itself.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ice40_ram_fifo.sv
// Single-clock valid/ready FIFO on iCE40 block RAM. The RAM's registered read port
// is the output stage, so capacity is DEPTH + 1 words.
//   CLK, ASYNCRESETN        - clock, async active-low reset
//   FLUSH                   - synchronous clear, wins over push/pop
//   WDATA, WVALID, WREADY   - write side handshake
//   RDATA, RVALID, RREADY   - read side handshake
//   COUNT, ALMOST_FULL      - occupancy and COUNT >= AFULL_LEVEL
module ice40_ram_fifo import ice40_ram_pkg::*; #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned AFULL_LEVEL = DEPTH - 2
) (
   input  logic                        CLK,
   input  logic                        ASYNCRESETN,
   input  logic                        FLUSH,
   input  logic [WIDTH-1:0]            WDATA,
   input  logic                        WVALID,
   output logic                        WREADY,
   output logic [WIDTH-1:0]            RDATA,
   output logic                        RVALID,
   input  logic                        RREADY,
   output logic [clog2(DEPTH+2)-1:0]   COUNT,
   output logic                        ALMOST_FULL
);

   localparam int unsigned AW  = clog2(DEPTH);
   localparam int unsigned RCW = clog2(DEPTH + 1);
   localparam int unsigned CW  = clog2(DEPTH + 2);

   localparam logic [RCW-1:0] RamFull    = RCW'(DEPTH);
   localparam logic [CW-1:0]  AfullLevel = CW'(AFULL_LEVEL);

   if (!fifo_params_ok(WIDTH, DEPTH, AFULL_LEVEL)) begin : gen_bad_params
      $error("ice40_ram_fifo: illegal WIDTH/DEPTH/AFULL_LEVEL");
   end

   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [RCW-1:0] ram_count_q, ram_count_d;
   logic           rvalid_q, rvalid_d;
   logic           rst_done_q;
   logic           push, pop, issue;

   // No path from RREADY: full is judged on the RAM alone.
   assign WREADY = rst_done_q && !FLUSH && (ram_count_q != RamFull);
   assign push   = WVALID && WREADY;
   assign pop    = rvalid_q && RREADY;
   // Refill the output stage whenever it is empty or being drained this edge.
   assign issue  = !FLUSH && (ram_count_q != '0) && (!rvalid_q || RREADY);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      ram_count_d = ram_count_q;
      rvalid_d    = rvalid_q;
      if (FLUSH) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         ram_count_d = '0;
         rvalid_d    = 1'b0;
      end else begin
         if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
         if (issue) rd_ptr_d = rd_ptr_q + AW'(1);
         ram_count_d = ram_count_q + RCW'(push) - RCW'(issue);
         if (issue) begin
            rvalid_d = 1'b1;
         end else if (pop) begin
            rvalid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ram_count_q <= '0;
         rvalid_q    <= 1'b0;
         rst_done_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         ram_count_q <= ram_count_d;
         rvalid_q    <= rvalid_d;
         rst_done_q  <= 1'b1;
      end
   end

   assign RVALID      = rvalid_q;
   assign COUNT       = CW'(ram_count_q) + CW'(rvalid_q);
   assign ALMOST_FULL = (COUNT >= AfullLevel);

   // Full blocks writes and empty blocks issues, so addresses never collide.
   ice40_ram_sdp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (CLK),
      .rst_n (ASYNCRESETN),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (WDATA),
      .re    (issue),
      .raddr (rd_ptr_q),
      .rdata (RDATA)
   );

endmodule

// File: tb/tb_ice40_ram_fifo.sv
// Self-checking bench for ice40_ram_fifo (WIDTH 16, DEPTH 4, AFULL_LEVEL 2).
// Reference model: a queue of RAM-held words plus one output-stage slot.
module tb_ice40_ram_fifo;

   localparam int DEPTH = 4;
   localparam int AFULL = 2;

   logic        clk, rst_n, flush, wvalid, wready, rvalid, rready, afull;
   logic [15:0] wdata, rdata;
   logic [2:0]  count;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   ice40_ram_fifo #(
      .WIDTH       (16),
      .DEPTH       (DEPTH),
      .AFULL_LEVEL (AFULL)
   ) dut (
      .CLK         (clk),
      .ASYNCRESETN (rst_n),
      .FLUSH       (flush),
      .WDATA       (wdata),
      .WVALID      (wvalid),
      .WREADY      (wready),
      .RDATA       (rdata),
      .RVALID      (rvalid),
      .RREADY      (rready),
      .COUNT       (count),
      .ALMOST_FULL (afull)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state
   logic [15:0] m_ram[$];
   bit          m_ov;
   logic [15:0] m_od;
   bit          m_done;
   bit          p_push, p_pop, p_issue, p_fl;
   logic [15:0] p_wd;
   logic [15:0] got[$];
   int          pop_cyc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ram.delete();
      m_ov   = 0;
      m_od   = '0;
      m_done = 0;
   endtask

   // Drive inputs, compare outputs against the model, decide what the edge will do.
   task automatic pre(input bit wv, input logic [15:0] wd, input bit rr, input bit fl);
      bit e_wready;
      int e_count;
      wvalid = wv; wdata = wd; rready = rr; flush = fl;
      #2;
      e_wready = m_done && !fl && (m_ram.size() != DEPTH);
      e_count  = m_ram.size() + (m_ov ? 1 : 0);
      check("m_wready", {31'd0, wready}, {31'd0, e_wready});
      check("m_rvalid", {31'd0, rvalid}, {31'd0, m_ov});
      check("m_rdata",  {16'd0, rdata},  {16'd0, m_od});
      check("m_count",  {29'd0, count},  e_count);
      check("m_afull",  {31'd0, afull},  {31'd0, (e_count >= AFULL)});
      p_fl    = fl;
      p_wd    = wd;
      p_push  = wv && e_wready;
      p_issue = m_done && !fl && (m_ram.size() != 0) && (!m_ov || rr);
      p_pop   = m_ov && rr && !fl;
      if (p_pop) begin
         got.push_back(m_od);
         pop_cyc.push_back(cyc);
      end
   endtask

   task automatic post();
      @(posedge clk);
      cyc++;
      if (p_fl) begin
         m_ram.delete();
         m_ov = 0;
      end else begin
         if (p_issue) begin
            m_od = m_ram.pop_front();
            m_ov = 1;
         end else if (p_pop) begin
            m_ov = 0;
         end
         if (p_push) m_ram.push_back(p_wd);
      end
      if (rst_n) m_done = 1;
      #1;
   endtask

   task automatic cycle(input bit wv, input logic [15:0] wd, input bit rr, input bit fl);
      pre(wv, wd, rr, fl);
      post();
   endtask

   typedef struct {
      bit          wv;
      logic [15:0] wd;
      bit          rr;
      bit          e_wready;
      bit          e_rvalid;
      logic [15:0] e_rdata;
      int          e_count;
      bit          e_afull;
   } vec_t;

   vec_t tbl[12];

   initial begin
      // Fill to DEPTH+1 with RREADY low, then drain; first word doubles as 0x00FE test.
      tbl[0]  = '{1, 16'h00FE, 0, 1, 0, 16'h0000, 0, 0};
      tbl[1]  = '{1, 16'h0002, 0, 1, 0, 16'h0000, 1, 0};
      tbl[2]  = '{1, 16'h0003, 0, 1, 1, 16'h00FE, 2, 1};
      tbl[3]  = '{1, 16'h0004, 0, 1, 1, 16'h00FE, 3, 1};
      tbl[4]  = '{1, 16'h0005, 0, 1, 1, 16'h00FE, 4, 1};
      tbl[5]  = '{0, 16'h0000, 0, 0, 1, 16'h00FE, 5, 1};
      tbl[6]  = '{1, 16'h0006, 1, 0, 1, 16'h00FE, 5, 1};
      tbl[7]  = '{0, 16'h0000, 1, 1, 1, 16'h0002, 4, 1};
      tbl[8]  = '{0, 16'h0000, 1, 1, 1, 16'h0003, 3, 1};
      tbl[9]  = '{0, 16'h0000, 1, 1, 1, 16'h0004, 2, 1};
      tbl[10] = '{0, 16'h0000, 1, 1, 1, 16'h0005, 1, 0};
      tbl[11] = '{0, 16'h0000, 0, 1, 0, 16'h0005, 0, 0};

      // Reset with WVALID held high
      rst_n = 1'b0; wvalid = 1'b1; wdata = 16'hAAAA; rready = 1'b0; flush = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_wready", {31'd0, wready}, 0);
      check("rst_rvalid", {31'd0, rvalid}, 0);
      check("rst_rdata",  {16'd0, rdata},  0);
      check("rst_count",  {29'd0, count},  0);
      check("rst_afull",  {31'd0, afull},  0);
      rst_n = 1'b1;
      #2;
      check("release_wready", {31'd0, wready}, 0);
      @(posedge clk);
      #1;
      m_done = 1;
      check("release_nopush_count", {29'd0, count}, 0);
      check("release_wready_up",    {31'd0, wready}, 1);

      // Table-driven fill and drain
      foreach (tbl[i]) begin
         pre(tbl[i].wv, tbl[i].wd, tbl[i].rr, 1'b0);
         check($sformatf("v%0d_wready", i), {31'd0, wready}, {31'd0, tbl[i].e_wready});
         check($sformatf("v%0d_rvalid", i), {31'd0, rvalid}, {31'd0, tbl[i].e_rvalid});
         check($sformatf("v%0d_rdata", i),  {16'd0, rdata},  {16'd0, tbl[i].e_rdata});
         check($sformatf("v%0d_count", i),  {29'd0, count},  tbl[i].e_count);
         check($sformatf("v%0d_afull", i),  {31'd0, afull},  {31'd0, tbl[i].e_afull});
         post();
      end

      // Continuous push/pop of 20 words: wrap-around, order, no bubbles
      got.delete();
      pop_cyc.delete();
      for (int i = 0; i < 24; i++) cycle(i < 20, 16'h0100 + 16'(i), 1'b1, 1'b0);
      check("stream_len", got.size(), 20);
      for (int i = 0; i < 20 && i < got.size(); i++)
         check($sformatf("stream_word%0d", i), {16'd0, got[i]}, 32'h100 + i);
      if (pop_cyc.size() == 20)
         check("stream_nobubble", pop_cyc[19] - pop_cyc[0], 19);

      // Flush with COUNT 3 and a write attempt
      cycle(1'b1, 16'h0011, 1'b0, 1'b0);
      cycle(1'b1, 16'h0022, 1'b0, 1'b0);
      cycle(1'b1, 16'h0033, 1'b0, 1'b0);
      check("pre_flush_count", {29'd0, count}, 3);
      pre(1'b1, 16'h0044, 1'b0, 1'b1);
      check("flush_wready", {31'd0, wready}, 0);
      post();
      check("flush_count",  {29'd0, count},  0);
      check("flush_rvalid", {31'd0, rvalid}, 0);
      check("flush_rdata_hold", {16'd0, rdata}, 32'h0011);
      cycle(1'b1, 16'h0055, 1'b0, 1'b0);
      check("after_flush_n_rvalid", {31'd0, rvalid}, 0);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0);
      check("after_flush_n1_rvalid", {31'd0, rvalid}, 1);
      check("after_flush_n1_rdata",  {16'd0, rdata},  32'h0055);
      cycle(1'b0, 16'h0000, 1'b1, 1'b0);

      // Asynchronous reset between edges
      cycle(1'b1, 16'h0066, 1'b0, 1'b0);
      cycle(1'b1, 16'h0077, 1'b0, 1'b0);
      cycle(1'b1, 16'h0088, 1'b0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_rvalid", {31'd0, rvalid}, 0);
      check("arst_count",  {29'd0, count},  0);
      check("arst_wready", {31'd0, wready}, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 1) == 1,
               $urandom_range(0, 31) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
